// File: rtl/mux_nx1_rr.sv
// N-to-1 valid/ready multiplexer with a one-beat output register.
// A channel is chosen either by a fixed select input or by a round-robin pointer.
module mux_nx1_rr #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SELW  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(1<<SELW)*WIDTH-1:0]  in_data,
  input  logic [(1<<SELW)-1:0]        in_valid,
  output logic [(1<<SELW)-1:0]        in_ready,
  input  logic                        mode,
  input  logic [SELW-1:0]             sel,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SELW-1:0]             out_ch
);

  localparam int unsigned N = 1 << SELW;

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             load_en;
  logic             grant_vld;
  logic [SELW-1:0]  grant_ch;
  logic [SELW-1:0]  idx;
  logic [WIDTH-1:0] grant_data;

  // Arbitration: fixed select, or first valid channel after the pointer (pointer last).
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    if (!mode) begin
      grant_vld = in_valid[sel];
      grant_ch  = sel;
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        idx = ptr_q + SELW'(k);
        if (!grant_vld && in_valid[idx]) begin
          grant_vld = 1'b1;
          grant_ch  = idx;
        end
      end
    end
  end

  // Data path select with constant part-selects only.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_ch == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign load_en = !out_valid_q || out_ready;

  always_comb begin
    in_ready = '0;
    in_ready[grant_ch] = load_en && grant_vld && !rst;
  end

  // Output register and pointer next-state.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = grant_data;
        out_ch_d   = grant_ch;
        if (mode) ptr_d = grant_ch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= SELW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: directed scenarios plus randomized traffic checked
// against an abstract arbitration model.
module tb_mux_nx1_rr;

  localparam int WIDTH = 8;
  localparam int SELW  = 2;
  localparam int N     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [SELW-1:0]  sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SELW-1:0]  out_ch;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit       m_valid;
  bit [7:0] m_data;
  int       m_ch;
  int       m_ptr;

  mux_nx1_rr #(.WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  function automatic void model_grant(output bit ok, output int g);
    ok = 1'b0;
    g  = 0;
    if (rst) return;
    if (!mode) begin
      ok = in_valid[sel];
      g  = int'(sel);
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!ok && in_valid[c]) begin
          ok = 1'b1;
          g  = c;
        end
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_ready();
    bit ok;
    int g;
    logic [N-1:0] r;
    r = '0;
    model_grant(ok, g);
    if (ok && (!m_valid || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    bit ok;
    int g;
    model_grant(ok, g);
    if (rst) begin
      m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = N - 1;
    end else if (!m_valid || out_ready) begin
      m_valid = ok;
      if (ok) begin
        m_data = in_data[g*WIDTH +: WIDTH];
        m_ch   = g;
        if (mode) m_ptr = g;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_data();
    in_data = {$urandom, $urandom} & {N*WIDTH{1'b1}};
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    in_valid = 4'b1111; rand_data();
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (in_ready !== 4'b0000) begin
        fails++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
        fails++; $display("FAIL reset_outputs: got v=%b d=%h ch=%0d expected v=0 d=00 ch=0",
                          out_valid, out_data, out_ch);
      end
    end
  endtask

  task automatic test_fixed();
    rst = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    rand_data(); in_data[2*WIDTH +: WIDTH] = 8'hA5;
    #1;
    tests++;
    if (in_ready !== 4'b0100) begin
      fails++; $display("FAIL fixed_in_ready: got %b expected 0100", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      fails++; $display("FAIL fixed_load: got v=%b d=%h ch=%0d expected v=1 d=a5 ch=2",
                        out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_rr_all();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; tick();
    rst = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      tick();
      tests++;
      if (out_valid !== 1'b1 || int'(out_ch) != exp_seq[i]) begin
        fails++; $display("FAIL rr_all_seq[%0d]: got v=%b ch=%0d expected v=1 ch=%0d",
                          i, out_valid, out_ch, exp_seq[i]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_ch;
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    exp_ch = 1;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      #1;
      tests++;
      if (in_ready[0] !== 1'b0 || in_ready[2] !== 1'b0) begin
        fails++; $display("FAIL rr_sparse_ready: got %b expected bits 0,2 clear", in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || int'(out_ch) != exp_ch) begin
        fails++; $display("FAIL rr_sparse_ch[%0d]: got ch=%0d expected %0d", i, out_ch, exp_ch);
      end
      exp_ch = (exp_ch == 1) ? 3 : 1;
    end
  endtask

  task automatic test_back_to_back_stall();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
    rand_data(); in_data[0 +: WIDTH] = 8'h3C;
    tick();
    out_ready = 1'b0; in_valid = 4'b1111; in_data[0 +: WIDTH] = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (in_ready !== 4'b0000) begin
        fails++; $display("FAIL stall_in_ready[%0d]: got %b expected 0000", i, in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd0) begin
        fails++; $display("FAIL stall_hold[%0d]: got v=%b d=%h ch=%0d expected v=1 d=3c ch=0",
                          i, out_valid, out_data, out_ch);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0001) begin
      fails++; $display("FAIL stall_release_ready: got %b expected 0001", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h77) begin
      fails++; $display("FAIL stall_release_data: got v=%b d=%h expected v=1 d=77",
                        out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b0; sel = 2'd3; in_valid = 4'b1000; out_ready = 1'b0; rand_data();
    tick();
    rst = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0000) begin
      fails++; $display("FAIL midrst_in_ready: got %b expected 0000", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      fails++; $display("FAIL midrst_clear: got v=%b d=%h ch=%0d expected v=0 d=00 ch=0",
                        out_valid, out_data, out_ch);
    end
    rst = 1'b0; mode = 1'b1; in_valid = 4'b1001; out_ready = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
      fails++; $display("FAIL midrst_first: got v=%b ch=%0d expected v=1 ch=0", out_valid, out_ch);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_ch !== 2'd3) begin
      fails++; $display("FAIL midrst_second: got v=%b ch=%0d expected v=1 ch=3", out_valid, out_ch);
    end
  endtask

  task automatic test_fixed_empty();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1; rand_data();
    tick();
    in_valid = 4'b1101;
    #1;
    tests++;
    if (in_ready !== 4'b0000) begin
      fails++; $display("FAIL fixed_empty_ready: got %b expected 0000", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL fixed_empty_drain: got v=%b expected 0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel       = SELW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      #1;
      tests++;
      if (in_ready !== exp_ready()) begin
        fails++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, in_ready, exp_ready());
      end
      tick();
      tests++;
      if (out_valid !== m_valid || out_data !== m_data || int'(out_ch) != m_ch) begin
        fails++; $display("FAIL rand_out[%0d]: got v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d",
                          i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
      end
    end
  endtask

  initial begin
    m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = N - 1;
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_back_to_back_stall();
    test_reset_mid();
    test_fixed_empty();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
